// File: rtl/alu_seq_exec.sv
// Execute unit for the MIPS core: single-cycle ALU and immediate ops, plus
// iterative mult/multu/div/divu into HI/LO, all behind valid/ready handshakes.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             wr_rt,
  output logic             illegal,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_srcA;

  logic               r_outValid;
  logic [WIDTH-1:0]   r_result;
  logic               r_wrEn;
  logic               r_wrRt;
  logic               r_illegal;
  logic               r_divZeroOut;

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [SHAMT_W-1:0] w_shamt;
  logic [15:0]        w_imm;
  logic [WIDTH-1:0]   w_immSext;
  logic [WIDTH-1:0]   w_immZext;
  logic [WIDTH-1:0]   w_immLui;
  logic               w_unused;

  logic [WIDTH-1:0]   w_aluRes;
  logic               w_wrEn;
  logic               w_wrRt;
  logic               w_illegal;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_signed;

  logic               w_accept;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;

  logic [2*WIDTH-1:0] w_prodNext;
  logic [2*WIDTH-1:0] w_prodFinal;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic [WIDTH-1:0]   w_quoFinal;
  logic [WIDTH-1:0]   w_remFinal;
  logic               w_lastIter;
  logic               w_finish;

  assign w_op      = instr[31:26];
  assign w_funct   = instr[5:0];
  assign w_shamt   = instr[SHAMT_W+5:6];
  assign w_imm     = instr[15:0];
  assign w_immSext = WIDTH'($signed(w_imm));
  assign w_immZext = WIDTH'(w_imm);
  assign w_immLui  = WIDTH'({w_imm, 16'h0000});
  // Register specifiers were already consumed by operand fetch.
  assign w_unused  = ^instr[25:SHAMT_W+6];

  assign in_ready  = (r_state == S_IDLE) && (!r_outValid || out_ready);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_aluRes  = '0;
    w_wrEn    = 1'b1;
    w_wrRt    = 1'b0;
    w_illegal = 1'b0;
    w_isMul   = 1'b0;
    w_isDiv   = 1'b0;
    w_signed  = 1'b0;
    if (w_op == 6'b000000) begin
      case (w_funct)
        6'b100000, 6'b100001: w_aluRes = src_a + src_b;
        6'b100010, 6'b100011: w_aluRes = src_a - src_b;
        6'b100100:            w_aluRes = src_a & src_b;
        6'b100101:            w_aluRes = src_a | src_b;
        6'b100110:            w_aluRes = src_a ^ src_b;
        6'b100111:            w_aluRes = ~(src_a | src_b);
        6'b101010:            w_aluRes = WIDTH'($signed(src_a) < $signed(src_b));
        6'b101011:            w_aluRes = WIDTH'(src_a < src_b);
        6'b000000:            w_aluRes = src_b << w_shamt;
        6'b000010:            w_aluRes = src_b >> w_shamt;
        6'b000011:            w_aluRes = $signed(src_b) >>> w_shamt;
        6'b010000:            w_aluRes = r_hi;
        6'b010010:            w_aluRes = r_lo;
        6'b011000: begin
          w_isMul  = 1'b1;
          w_signed = 1'b1;
        end
        6'b011001:            w_isMul  = 1'b1;
        6'b011010: begin
          w_isDiv  = 1'b1;
          w_signed = 1'b1;
        end
        6'b011011:            w_isDiv  = 1'b1;
        default: begin
          w_wrEn    = 1'b0;
          w_illegal = 1'b1;
        end
      endcase
    end else begin
      w_wrRt = 1'b1;
      case (w_op)
        6'b001000, 6'b001001: w_aluRes = src_a + w_immSext;
        6'b001010:            w_aluRes = WIDTH'($signed(src_a) < $signed(w_immSext));
        6'b001011:            w_aluRes = WIDTH'(src_a < w_immSext);
        6'b001100:            w_aluRes = src_a & w_immZext;
        6'b001101:            w_aluRes = src_a | w_immZext;
        6'b001110:            w_aluRes = src_a ^ w_immZext;
        6'b001111:            w_aluRes = w_immLui;
        default: begin
          w_wrEn    = 1'b0;
          w_wrRt    = 1'b0;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  // Both iterative units work on magnitudes; signs are reapplied on the last step.
  assign w_aNeg = w_signed && src_a[WIDTH-1];
  assign w_bNeg = w_signed && src_b[WIDTH-1];
  assign w_aMag = w_aNeg ? -src_a : src_a;
  assign w_bMag = w_bNeg ? -src_b : src_b;

  assign w_prodNext  = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_prodFinal = r_negRes ? -w_prodNext : w_prodNext;

  assign w_remShift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvsr};
  assign w_fits     = !w_diff[WIDTH];
  assign w_remNext  = w_fits ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
  assign w_quoNext  = {r_quo[WIDTH-2:0], w_fits};
  assign w_quoFinal = r_divZero ? '1 : (r_negRes ? -w_quoNext : w_quoNext);
  assign w_remFinal = r_divZero ? r_srcA : (r_negRem ? -w_remNext : w_remNext);

  assign w_lastIter = (r_cnt == LAST_ITER);
  assign w_finish   = ((r_state == S_MUL) || (r_state == S_DIV)) && w_lastIter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_srcA    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_isMul || w_isDiv)) begin
            r_state   <= w_isMul ? S_MUL : S_DIV;
            r_cnt     <= '0;
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_divZero <= w_isDiv && (src_b == '0);
            r_srcA    <= src_a;
            r_mcand   <= {{WIDTH{1'b0}}, w_aMag};
            r_mplier  <= w_bMag;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= w_aMag;
            r_dvsr    <= w_bMag;
          end
        end
        S_MUL: begin
          r_prod   <= w_prodNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_lastIter) begin
            {r_hi, r_lo} <= w_prodFinal;
            r_state      <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt + 1'b1;
          if (w_lastIter) begin
            r_hi    <= w_remFinal;
            r_lo    <= w_quoFinal;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: load on a single-cycle accept or mult/div completion, else drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_result     <= '0;
      r_wrEn       <= 1'b0;
      r_wrRt       <= 1'b0;
      r_illegal    <= 1'b0;
      r_divZeroOut <= 1'b0;
    end else if (w_accept && !w_isMul && !w_isDiv) begin
      r_outValid   <= 1'b1;
      r_result     <= w_aluRes;
      r_wrEn       <= w_wrEn;
      r_wrRt       <= w_wrRt;
      r_illegal    <= w_illegal;
      r_divZeroOut <= 1'b0;
    end else if (w_finish) begin
      r_outValid   <= 1'b1;
      r_wrEn       <= 1'b0;
      r_wrRt       <= 1'b0;
      r_illegal    <= 1'b0;
      r_divZeroOut <= r_divZero;
    end else if (out_ready) begin
      r_outValid   <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign wr_en     = r_wrEn;
  assign wr_rt     = r_wrRt;
  assign illegal   = r_illegal;
  assign div_zero  = r_divZeroOut;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios plus randomized
// instruction mix scored against an arithmetic reference model.
module tb_alu_seq_exec;

  localparam int W = 32;

  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] O_ADDI = 6'b001000, O_ADDIU = 6'b001001, O_SLTI = 6'b001010, O_SLTIU = 6'b001011;
  localparam logic [5:0] O_ANDI = 6'b001100, O_ORI = 6'b001101, O_XORI = 6'b001110, O_LUI = 6'b001111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         wr_en;
  logic         wr_rt;
  logic         illegal;
  logic         div_zero;

  int nPass  = 0;
  int nTotal = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .wr_en(wr_en), .wr_rt(wr_rt),
    .illegal(illegal), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rEnc(input logic [5:0] fn, input logic [4:0] sh);
    return {6'b000000, 15'h0000, sh, fn};
  endfunction

  function automatic logic [31:0] iEnc(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h000, imm};
  endfunction

  // Reference model straight from the instruction semantics, 64-bit arithmetic for mult/div.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic we, output logic wrt,
                                output logic ill, output logic dz, output int lat);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] se;
    logic [31:0] ze;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; we = 1'b1; wrt = (op != 6'b0); ill = 1'b0; dz = 1'b0; lat = 1;
    if (op == 6'b000000) begin
      case (fn)
        F_ADD, F_ADDU: res = a + b;
        F_SUB, F_SUBU: res = a - b;
        F_AND:  res = a & b;
        F_OR:   res = a | b;
        F_XOR:  res = a ^ b;
        F_NOR:  res = ~(a | b);
        F_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
        F_SLTU: res = (a < b) ? 32'd1 : 32'd0;
        F_SLL:  res = b << sh;
        F_SRL:  res = b >> sh;
        F_SRA:  res = 32'(sb >>> sh);
        F_MFHI: res = mHi;
        F_MFLO: res = mLo;
        F_MULT: begin
          p = 64'(sa * sb);
          mHi = p[63:32]; mLo = p[31:0]; we = 1'b0; lat = 33;
        end
        F_MULTU: begin
          p = {32'h0, a} * {32'h0, b};
          mHi = p[63:32]; mLo = p[31:0]; we = 1'b0; lat = 33;
        end
        F_DIV, F_DIVU: begin
          we = 1'b0; lat = 33;
          if (b == 32'h0) begin
            mLo = 32'hFFFF_FFFF; mHi = a; dz = 1'b1;
          end else if (fn == F_DIV) begin
            q = sa / sb; r = sa % sb;
            mLo = 32'(q); mHi = 32'(r);
          end else begin
            mLo = a / b; mHi = a % b;
          end
        end
        default: begin we = 1'b0; ill = 1'b1; end
      endcase
    end else begin
      case (op)
        O_ADDI, O_ADDIU: res = a + se;
        O_SLTI:  res = (sa < longint'($signed(se))) ? 32'd1 : 32'd0;
        O_SLTIU: res = (a < se) ? 32'd1 : 32'd0;
        O_ANDI:  res = a & ze;
        O_ORI:   res = a | ze;
        O_XORI:  res = a ^ ze;
        O_LUI:   res = {ins[15:0], 16'h0000};
        default: begin we = 1'b0; wrt = 1'b0; ill = 1'b1; end
      endcase
    end
  endfunction

  // Issues one instruction with out_ready high and waits (bounded) for its result.
  task automatic doOp(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output logic we, output logic wrt,
                      output logic ill, output logic dz, output int lat);
    int n;
    @(negedge clk);
    instr = ins; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result; we = wr_en; wrt = wr_rt; ill = illegal; dz = div_zero;
  endtask

  task automatic test_reset();
    logic [31:0] res;
    logic we, wrt, ill, dz;
    int lat;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; src_a = '0; src_b = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nTotal++;
    if (out_valid !== 1'b0 || wr_en !== 1'b0 || wr_rt !== 1'b0 || illegal !== 1'b0 || div_zero !== 1'b0)
      $display("[TB] FAIL reset_flags got ov=%b we=%b rt=%b ill=%b dz=%b want all 0",
               out_valid, wr_en, wr_rt, illegal, div_zero);
    else nPass++;
    nTotal++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result got %h want 00000000", result);
    else nPass++;
    nTotal++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    else nPass++;
    rst_n = 1'b1;
    mHi = '0; mLo = '0;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h0) $display("[TB] FAIL reset_hi got %h want 00000000", res);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h0) $display("[TB] FAIL reset_lo got %h want 00000000", res);
    else nPass++;
  endtask

  task automatic test_addi();
    logic [31:0] res;
    logic we, wrt, ill, dz;
    int lat;
    doOp(iEnc(O_ADDI, 16'hFFF9), 32'd5, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFFE || lat != 1)
      $display("[TB] FAIL addi_result got %h lat %0d want fffffffe lat 1", res, lat);
    else nPass++;
    nTotal++;
    if (we !== 1'b1 || wrt !== 1'b1 || ill !== 1'b0)
      $display("[TB] FAIL addi_flags got we=%b rt=%b ill=%b want 1 1 0", we, wrt, ill);
    else nPass++;
  endtask

  task automatic test_mult();
    logic [31:0] res, eRes;
    logic we, wrt, ill, dz, eWe, eWrt, eIll, eDz;
    int lat, eLat, first, rdyHigh;
    @(negedge clk);
    out_ready = 1'b0; instr = rEnc(F_MULT, 5'd0); src_a = 32'hFFFF_FFFD; src_b = 32'd7; in_valid = 1'b1;
    nTotal++;
    if (in_ready !== 1'b1) $display("[TB] FAIL mult_accept_ready got %b want 1", in_ready);
    else nPass++;
    model(instr, src_a, src_b, eRes, eWe, eWrt, eIll, eDz, eLat);
    @(posedge clk);
    first = 0; rdyHigh = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (in_ready) rdyHigh++;
      if (out_valid) first = c;
    end
    nTotal++;
    if (first != 33) $display("[TB] FAIL mult_latency got %0d want 33", first);
    else nPass++;
    nTotal++;
    if (rdyHigh != 0) $display("[TB] FAIL mult_in_ready_low got %0d high cycles want 0", rdyHigh);
    else nPass++;
    nTotal++;
    if (wr_en !== 1'b0 || illegal !== 1'b0 || div_zero !== 1'b0)
      $display("[TB] FAIL mult_flags got we=%b ill=%b dz=%b want 0 0 0", wr_en, illegal, div_zero);
    else nPass++;
    out_ready = 1'b1;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_hi got %h want ffffffff", res);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFEB) $display("[TB] FAIL mult_lo got %h want ffffffeb", res);
    else nPass++;
    model(rEnc(F_MULTU, 5'd0), 32'hFFFF_FFFF, 32'd2, eRes, eWe, eWrt, eIll, eDz, eLat);
    doOp(rEnc(F_MULTU, 5'd0), 32'hFFFF_FFFF, 32'd2, res, we, wrt, ill, dz, lat);
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h1) $display("[TB] FAIL multu_hi got %h want 00000001", res);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFFE) $display("[TB] FAIL multu_lo got %h want fffffffe", res);
    else nPass++;
  endtask

  task automatic test_div();
    logic [31:0] res, eRes;
    logic we, wrt, ill, dz, eWe, eWrt, eIll, eDz;
    int lat, eLat;
    model(rEnc(F_DIV, 5'd0), 32'd7, 32'hFFFF_FFFE, eRes, eWe, eWrt, eIll, eDz, eLat);
    doOp(rEnc(F_DIV, 5'd0), 32'd7, 32'hFFFF_FFFE, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (lat != 33 || we !== 1'b0 || dz !== 1'b0)
      $display("[TB] FAIL div_done got lat=%0d we=%b dz=%b want 33 0 0", lat, we, dz);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFFD) $display("[TB] FAIL div_lo got %h want fffffffd", res);
    else nPass++;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h1) $display("[TB] FAIL div_hi got %h want 00000001", res);
    else nPass++;
    model(rEnc(F_DIVU, 5'd0), 32'h1234_5678, 32'h0, eRes, eWe, eWrt, eIll, eDz, eLat);
    doOp(rEnc(F_DIVU, 5'd0), 32'h1234_5678, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (dz !== 1'b1) $display("[TB] FAIL divu_zero_flag got %b want 1", dz);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'hFFFF_FFFF || dz !== 1'b0)
      $display("[TB] FAIL divu_zero_lo got %h dz=%b want ffffffff dz=0", res, dz);
    else nPass++;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h1234_5678) $display("[TB] FAIL divu_zero_hi got %h want 12345678", res);
    else nPass++;
    model(rEnc(F_DIV, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF, eRes, eWe, eWrt, eIll, eDz, eLat);
    doOp(rEnc(F_DIV, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF, res, we, wrt, ill, dz, lat);
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h8000_0000) $display("[TB] FAIL div_min_lo got %h want 80000000", res);
    else nPass++;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h0) $display("[TB] FAIL div_min_hi got %h want 00000000", res);
    else nPass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
    e1 = a1 + b1; e2 = a2 - b2;
    @(negedge clk);
    out_ready = 1'b0; instr = rEnc(F_ADD, 5'd0); src_a = a1; src_b = b1; in_valid = 1'b1;
    nTotal++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_first_ready got %b want 1", in_ready);
    else nPass++;
    @(posedge clk);
    @(negedge clk);
    instr = rEnc(F_SUB, 5'd0); src_a = a2; src_b = b2;
    for (int k = 1; k <= 5; k++) begin
      nTotal++;
      if (out_valid !== 1'b1 || result !== e1 || in_ready !== 1'b0)
        $display("[TB] FAIL bp_hold%0d got ov=%b res=%h rdy=%b want ov=1 res=%h rdy=0",
                 k, out_valid, result, in_ready, e1);
      else nPass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    nTotal++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", in_ready);
    else nPass++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    nTotal++;
    if (out_valid !== 1'b1 || result !== e2 || wr_en !== 1'b1 || wr_rt !== 1'b0)
      $display("[TB] FAIL bp_second got ov=%b res=%h we=%b rt=%b want 1 %h 1 0",
               out_valid, result, wr_en, wr_rt, e2);
    else nPass++;
  endtask

  task automatic test_reset_mid_mult();
    logic [31:0] res;
    logic we, wrt, ill, dz;
    int lat, seen;
    @(negedge clk);
    out_ready = 1'b1; instr = rEnc(F_MULT, 5'd0); src_a = 32'd1234; src_b = 32'd5678; in_valid = 1'b1;
    nTotal++;
    if (in_ready !== 1'b1) $display("[TB] FAIL rstmul_accept_ready got %b want 1", in_ready);
    else nPass++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nTotal++;
    if (out_valid !== 1'b0) $display("[TB] FAIL rstmul_out_valid got %b want 0", out_valid);
    else nPass++;
    mHi = '0; mLo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    nTotal++;
    if (seen != 0) $display("[TB] FAIL rstmul_no_completion got %0d valid cycles want 0", seen);
    else nPass++;
    doOp(rEnc(F_MFHI, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h0) $display("[TB] FAIL rstmul_hi got %h want 00000000", res);
    else nPass++;
    doOp(rEnc(F_MFLO, 5'd0), 32'h0, 32'h0, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'h0) $display("[TB] FAIL rstmul_lo got %h want 00000000", res);
    else nPass++;
    doOp(rEnc(F_ADD, 5'd0), 32'd3, 32'd4, res, we, wrt, ill, dz, lat);
    nTotal++;
    if (res !== 32'd7 || lat != 1 || we !== 1'b1)
      $display("[TB] FAIL rstmul_add got res=%h lat=%0d we=%b want 00000007 1 1", res, lat, we);
    else nPass++;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random(input int n);
    logic [5:0] rf [0:18] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                              F_SLL, F_SRL, F_SRA, F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0] io [0:7] = '{O_ADDI, O_ADDIU, O_SLTI, O_SLTIU, O_ANDI, O_ORI, O_XORI, O_LUI};
    logic [31:0] r, ins, a, b, res, eRes;
    logic we, wrt, ill, dz, eWe, eWrt, eIll, eDz;
    int lat, eLat, k;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      k = $urandom_range(0, 9);
      if (k < 5) ins = {6'b000000, r[25:6], rf[$urandom_range(0, 18)]};
      else if (k < 9) ins = {io[$urandom_range(0, 7)], r[25:0]};
      else if (r[0]) ins = {6'b000010, r[25:0]};
      else ins = {6'b000000, r[25:6], 6'b001000};
      a = pick();
      b = pick();
      model(ins, a, b, eRes, eWe, eWrt, eIll, eDz, eLat);
      doOp(ins, a, b, res, we, wrt, ill, dz, lat);
      nTotal++;
      if (we !== eWe || ill !== eIll || dz !== eDz)
        $display("[TB] FAIL rnd%0d_flags instr %h got we=%b ill=%b dz=%b want %b %b %b",
                 i, ins, we, ill, dz, eWe, eIll, eDz);
      else nPass++;
      nTotal++;
      if (lat != eLat) $display("[TB] FAIL rnd%0d_latency instr %h got %0d want %0d", i, ins, lat, eLat);
      else nPass++;
      if (eWe) begin
        nTotal++;
        if (res !== eRes || wrt !== eWrt)
          $display("[TB] FAIL rnd%0d_result instr %h a %h b %h got %h rt=%b want %h rt=%b",
                   i, ins, a, b, res, wrt, eRes, eWrt);
        else nPass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mult();
    test_div();
    test_backpressure();
    test_reset_mid_mult();
    test_random(60);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
